// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline types: widths, fetch FSM states, queue entry layout,
// and the instruction-memory address legality helper.
package pipeline_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // A fetch is legal when word-aligned and all four bytes lie inside memory.
  // Comparing against mem_size-4 avoids the wrap of adr+3 near 2^64.
  function automatic logic fetch_addr_ok(input logic [ADDR_W-1:0] adr,
                                         input logic [ADDR_W-1:0] mem_size);
    fetch_addr_ok = (adr[1:0] == 2'b00) &&
                    (mem_size >= 64'd4) &&
                    (adr <= (mem_size - 64'd4));
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch bus: instruction-memory port, redirect request and decode handshake.
interface fetch_if;
  import pipeline_pkg::*;

  logic [ADDR_W-1:0]  imem_adr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_pc;
  logic [INSTR_W-1:0] out_instr;

  modport master (
    output imem_adr, out_valid, out_pc, out_instr,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_adr, out_valid, out_pc, out_instr,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, instr} entries. Flush empties it and wins
// over push/pop in the same cycle; push at full is allowed when a pop
// frees the head slot in that same cycle.
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_push_entry,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == CNT_W'(0));
  assign w_do_pop  = i_pop && !w_empty && !i_flush;
  assign w_do_push = i_push && (!w_full || w_do_pop) && !i_flush;

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_head  = r_mem[r_rd_ptr];

  // Entry storage: written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  // Pointers and occupancy; power-of-two depth makes pointer wrap natural.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd_ptr <= PTR_W'(0);
      r_wr_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      else           r_wr_ptr <= r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      else           r_rd_ptr <= r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch front end: walks the fetch PC through instruction memory,
// buffers {pc, instr} in a small queue toward decode, honours redirects and
// halts in FAULT on an illegal or misaligned fetch address.
module fetch_controller
  import pipeline_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          MEM_SIZE = 64,
  parameter int          DEPTH    = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic fetch_en,
  fetch_if.master bus,
  output logic fault
);

  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_SIZE);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_fpc;
  logic              r_fault;

  fetch_entry_t w_entry;
  fetch_entry_t w_head;
  logic         w_full;
  logic         w_empty;
  logic         w_fpc_ok;
  logic         w_redir_ok;
  logic         w_pop;
  logic         w_push;

  assign w_fpc_ok   = fetch_addr_ok(r_fpc, MEM_BYTES);
  assign w_redir_ok = fetch_addr_ok(bus.redirect_pc, MEM_BYTES);
  assign w_pop      = !w_empty && bus.out_ready;
  // Redirect suppresses the enqueue; fetch_en=0 holds the fetch address.
  assign w_push     = (r_state == FETCH) && fetch_en && w_fpc_ok &&
                      (!w_full || w_pop) && !bus.redirect_valid;
  assign w_entry    = '{pc: r_fpc, instr: bus.imem_instr};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_flush      (bus.redirect_valid),
    .i_push_entry (w_entry),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  assign bus.imem_adr  = r_fpc;
  assign bus.out_valid = !w_empty;
  assign bus.out_pc    = w_head.pc;
  assign bus.out_instr = w_head.instr;
  assign fault         = r_fault;

  // Fetch FSM with fetch-PC update and registered fault flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_fpc   <= RESET_PC;
      r_fault <= 1'b0;
    end else begin
      if (bus.redirect_valid) r_fpc <= bus.redirect_pc;
      else if (w_push)        r_fpc <= r_fpc + 64'd4;
      else                    r_fpc <= r_fpc;

      case (r_state)
        IDLE: begin
          r_state <= fetch_en ? FETCH : IDLE;
          r_fault <= 1'b0;
        end
        FETCH: begin
          // A redirect replaces the current fpc, so only a non-redirected
          // illegal fpc faults; a bad redirect target faults one edge later.
          if (!fetch_en) begin
            r_state <= IDLE;
            r_fault <= 1'b0;
          end else if (!bus.redirect_valid && !w_fpc_ok) begin
            r_state <= FAULT;
            r_fault <= 1'b1;
          end else begin
            r_state <= FETCH;
            r_fault <= 1'b0;
          end
        end
        FAULT: begin
          if (bus.redirect_valid && w_redir_ok) begin
            r_state <= FETCH;
            r_fault <= 1'b0;
          end else begin
            r_state <= FAULT;
            r_fault <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_fault <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: byte-array instruction memory, scoreboard of
// expected {pc, instr} entries checked at every decode handshake, a table of
// fetch-address legality vectors, and directed multi-cycle sequences.
module tb_fetch_controller;
  import pipeline_pkg::*;

  logic clk;
  logic reset;
  logic fetch_en;
  logic fault;

  fetch_if bus();

  fetch_controller #(.RESET_PC(64'h0), .MEM_SIZE(64), .DEPTH(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .fetch_en (fetch_en),
    .bus      (bus),
    .fault    (fault)
  );

  logic [7:0]   mem [64];
  fetch_entry_t sb [$];
  int           n_checks = 0;
  int           n_fail   = 0;

  typedef struct {
    logic [63:0] pc;
    logic        exp_fault;
  } leg_vec_t;
  leg_vec_t vecs [10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian memory read for the address currently presented.
  always_comb begin
    logic [5:0] a;
    a = bus.imem_adr[5:0];
    if (bus.imem_adr <= 64'd60)
      bus.imem_instr = {mem[a + 6'd3], mem[a + 6'd2], mem[a + 6'd1], mem[a]};
    else
      bus.imem_instr = 32'd0;
  end

  function automatic logic [31:0] exp_word(input logic [63:0] pc);
    int i;
    i = int'(pc[5:0]);
    return {mem[i + 3], mem[i + 2], mem[i + 1], mem[i]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_stream(input logic [63:0] first_pc, input logic [63:0] last_pc);
    for (logic [63:0] p = first_pc; p <= last_pc; p = p + 64'd4)
      sb.push_back('{pc: p, instr: exp_word(p)});
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    fetch_en           = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'd0;
    sb.delete();
    step(2);
    reset = 1'b0;
  endtask

  // Scoreboard: every accepted head must be the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc=%0h instr=%0h expected none", bus.out_pc, bus.out_instr);
      end else begin
        fetch_entry_t e;
        e = sb.pop_front();
        if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
          n_fail++;
          $display("FAIL sb_entry: got pc=%0h instr=%0h expected pc=%0h instr=%0h",
                   bus.out_pc, bus.out_instr, e.pc, e.instr);
        end
      end
    end
  end

  initial begin
    // Memory image: program bytes then a filler pattern.
    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h93; mem[1] = 8'h00; mem[2]  = 8'h40; mem[3]  = 8'h01;
    mem[4] = 8'h23; mem[5] = 8'h20; mem[6]  = 8'h10; mem[7]  = 8'h00;
    mem[8] = 8'h03; mem[9] = 8'h21; mem[10] = 8'h00; mem[11] = 8'h00;

    vecs[0] = '{64'd0,                  1'b0};
    vecs[1] = '{64'd4,                  1'b0};
    vecs[2] = '{64'd6,                  1'b1};
    vecs[3] = '{64'd2,                  1'b1};
    vecs[4] = '{64'd56,                 1'b0};
    vecs[5] = '{64'd60,                 1'b0};
    vecs[6] = '{64'd61,                 1'b1};
    vecs[7] = '{64'd64,                 1'b1};
    vecs[8] = '{64'd124,                1'b1};
    vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b1};

    // Basic stream from reset through to the end-of-memory fault.
    do_reset();
    check("reset_valid", 64'(bus.out_valid), 64'd0);
    check("reset_fault", 64'(fault), 64'd0);
    check("reset_adr", bus.imem_adr, 64'h0);
    fetch_en      = 1'b1;
    bus.out_ready = 1'b1;
    sb.push_back('{pc: 64'd0, instr: 32'h01400093});
    sb.push_back('{pc: 64'd4, instr: 32'h00102023});
    sb.push_back('{pc: 64'd8, instr: 32'h00002103});
    push_stream(64'd12, 64'd60);
    step(1);
    check("lat_valid_c1", 64'(bus.out_valid), 64'd0);
    step(1);
    check("lat_valid_c2", 64'(bus.out_valid), 64'd1);
    check("lat_pc", bus.out_pc, 64'd0);
    check("lat_instr", 64'(bus.out_instr), 64'h01400093);
    step(23);
    check("end_fault", 64'(fault), 64'd1);
    check("end_valid", 64'(bus.out_valid), 64'd0);
    check("end_adr", bus.imem_adr, 64'd64);
    check("end_sb_drained", 64'(sb.size()), 64'd0);

    // Recover from FAULT by redirect to 0.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'd0;
    push_stream(64'd0, 64'd60);
    step(1);
    bus.redirect_valid = 1'b0;
    check("recover_fault", 64'(fault), 64'd0);
    step(1);
    check("recover_pc", bus.out_pc, 64'd0);
    step(20);
    check("recover_sb_drained", 64'(sb.size()), 64'd0);

    // Backpressure: fill, hold, stream at full, refill, then redirect.
    do_reset();
    fetch_en = 1'b1;
    push_stream(64'd0, 64'd60);
    step(5);
    check("full_valid", 64'(bus.out_valid), 64'd1);
    check("full_pc", bus.out_pc, 64'd0);
    check("full_instr", 64'(bus.out_instr), 64'h01400093);
    check("full_adr", bus.imem_adr, 64'd8);
    bus.out_ready = 1'b1;
    step(4);
    bus.out_ready = 1'b0;
    step(3);
    check("refill_pc", bus.out_pc, 64'd16);
    check("refill_adr", bus.imem_adr, 64'd24);
    check("refill_popped", 64'(sb.size()), 64'd12);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'd4;
    sb.delete();
    push_stream(64'd4, 64'd60);
    step(1);
    bus.redirect_valid = 1'b0;
    check("redir_flush_valid", 64'(bus.out_valid), 64'd0);
    check("redir_adr", bus.imem_adr, 64'd4);
    step(1);
    check("redir_valid", 64'(bus.out_valid), 64'd1);
    check("redir_pc", bus.out_pc, 64'd4);
    check("redir_instr", 64'(bus.out_instr), 64'h00102023);
    bus.out_ready = 1'b1;
    step(20);
    check("redir_sb_drained", 64'(sb.size()), 64'd0);
    check("redir_end_fault", 64'(fault), 64'd1);

    // Misaligned redirect, recovery, then reset mid-stream over a redirect.
    do_reset();
    fetch_en      = 1'b1;
    bus.out_ready = 1'b1;
    push_stream(64'd0, 64'd60);
    step(4);
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'd6;
    sb.delete();
    step(1);
    bus.redirect_valid = 1'b0;
    check("mis_adr", bus.imem_adr, 64'd6);
    check("mis_fault_c0", 64'(fault), 64'd0);
    check("mis_valid_c0", 64'(bus.out_valid), 64'd0);
    step(1);
    check("mis_fault_c1", 64'(fault), 64'd1);
    check("mis_valid_c1", 64'(bus.out_valid), 64'd0);
    check("mis_adr_hold", bus.imem_adr, 64'd6);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'd0;
    push_stream(64'd0, 64'd60);
    step(1);
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    step(3);
    reset              = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h20;
    sb.delete();
    step(1);
    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    fetch_en           = 1'b0;
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_adr", bus.imem_adr, 64'h0);
    check("midrst_fault", 64'(fault), 64'd0);

    // Legality table: load address in IDLE, start fetching, observe one edge.
    for (int v = 0; v < 10; v++) begin
      do_reset();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = vecs[v].pc;
      step(1);
      bus.redirect_valid = 1'b0;
      check($sformatf("leg%0d_adr", v), bus.imem_adr, vecs[v].pc);
      fetch_en = 1'b1;
      step(2);
      check($sformatf("leg%0d_fault", v), 64'(fault), 64'(vecs[v].exp_fault));
      check($sformatf("leg%0d_valid", v), 64'(bus.out_valid), 64'(!vecs[v].exp_fault));
      if (!vecs[v].exp_fault) begin
        check($sformatf("leg%0d_pc", v), bus.out_pc, vecs[v].pc);
        check($sformatf("leg%0d_instr", v), 64'(bus.out_instr), 64'(exp_word(vecs[v].pc)));
      end
    end

    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 64'h0, fetch address loaded on reset.
REQ-002 Parameter MEM_SIZE, default 64, instruction memory size in bytes; legal fetch iff adr+3 <= MEM_SIZE-1.
REQ-003 Parameter DEPTH, default 2, fetch queue entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fetch_en  input  1  permits fetching; 0 holds the current fetch address.
REQ-007 imem_adr  output  64  byte address to instruction memory.
REQ-008 imem_instr  input  32  little-endian instruction from memory, combinationally valid for imem_adr in the same cycle.
REQ-009 redirect_valid  input  1  branch/jump/flush request from execute.
REQ-010 redirect_pc  input  64  new fetch address when redirect_valid=1.
REQ-011 out_valid  output  1  queue head holds a valid instruction.
REQ-012 out_ready  input  1  decode accepts the head this cycle.
REQ-013 out_pc  output  64  address of the head instruction.
REQ-014 out_instr  output  32  head instruction word.
REQ-015 fault  output  1  fetch halted on an illegal or misaligned address.

Function
REQ-016 States: IDLE (fetch_en=0), FETCH, FAULT.
REQ-017 IDLE->FETCH when fetch_en=1; FETCH->IDLE when fetch_en=0; FETCH->FAULT when fpc is illegal or fpc[1:0]!=0; FAULT->FETCH only on redirect_valid with a legal, aligned redirect_pc.
REQ-018 imem_adr SHALL equal the fetch-PC register fpc at all times.
REQ-019 In FETCH with a legal, aligned fpc, and the queue not full or the head being dequeued this cycle, {fpc, imem_instr} SHALL be enqueued and fpc += 4 at the clock edge.
REQ-020 Fetch latency: an instruction enqueued at edge N SHALL appear on out_* in cycle N+1 when the queue was empty.
REQ-021 Dequeue occurs iff out_valid && out_ready; out_pc/out_instr SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 Simultaneous enqueue and dequeue at full SHALL keep count unchanged and lose no entry.
REQ-023 redirect_valid SHALL take priority: at that edge the queue is flushed (count=0), no enqueue occurs, a pending dequeue is discarded, and fpc <= redirect_pc.
REQ-024 A misaligned or illegal redirect_pc SHALL be loaded and SHALL move the FSM to FAULT at the next edge.
REQ-025 In FAULT, no enqueue occurs; queued entries still drain normally; fault=1.
REQ-026 Queue pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-027 fpc wraps modulo 2^64 and is never evaluated beyond the legality check.

Reset
REQ-028 While reset=1 at an edge: fpc=RESET_PC, state=IDLE, count=0, pointers=0; after reset: out_valid=0, fault=0, imem_adr=RESET_PC.
REQ-029 Reset mid-operation SHALL discard queued instructions and take priority over redirect_valid.
REQ-030 out_pc/out_instr are don't-care while out_valid=0.

Structure
REQ-031 Shared package pipeline_pkg holds the fetch-state enum (IDLE, FETCH, FAULT), the INSTR_W=32 / ADDR_W=64 constants, and the fetch-entry struct {pc, instr}.
REQ-032 The queue SHALL be a sub-module fetch_queue (DEPTH entries, push/pop/flush, full/empty); fetch_controller instantiates it and the existing instruction memory externally connects via imem_*.

Verification
REQ-033 Reset, fetch_en=1, out_ready=1, memory bytes 0..11 = 93 00 40 01 23 20 10 00 03 21 00 00 -> out_valid cycles 1..3 with (pc,instr) = (0,0x01400093), (4,0x00102023), (8,0x00002103).
REQ-034 out_ready=0 for 5 cycles -> queue fills to DEPTH, fpc stops at 8, out_* hold (0,0x01400093); out_ready=1 -> in-order stream, no loss or duplication.
REQ-035 Redirect to 0x4 while queue is full -> next cycle out_valid=0, following cycle (4,0x00102023).
REQ-036 Sequential fetch past MEM_SIZE=64 -> after pc 60 is enqueued, FSM enters FAULT, fault=1, queue drains; redirect to 0 -> fault=0, fetch resumes at pc 0.
REQ-037 Redirect to 0x6 -> FAULT next cycle, no enqueue; reset asserted mid-stream -> out_valid=0, imem_adr=RESET_PC the following cycle.
